// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: synchronises raw pins and a slow sampling tick, then
// accepts a level change only after STABLE_SAMPLES consecutive agreeing samples per button.
module button_debouncer #(
    parameter int unsigned NUM_BUTTONS    = 4,
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_in,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    localparam logic [3:0] StableCnt = 4'(STABLE_SAMPLES);
    localparam logic [NUM_BUTTONS-1:0] BtnInactive = ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    logic [NUM_BUTTONS-1:0] btn_s1_q, btn_s2_q;
    logic                   tick_s1_q, tick_s2_q, tick_prev_q;
    logic                   sample_en_d, sample_en_q;
    logic [NUM_BUTTONS-1:0] raw;

    state_e                 state_q [NUM_BUTTONS];
    state_e                 state_d [NUM_BUTTONS];
    logic [3:0]             cnt_q   [NUM_BUTTONS];
    logic [3:0]             cnt_d   [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] level_d, level_q;
    logic [NUM_BUTTONS-1:0] press_d, press_q;
    logic [NUM_BUTTONS-1:0] release_d, release_q;

    // Registered edge detect gives a one-clk sample pulse no matter how long tick_in stays high.
    assign sample_en_d = tick_s2_q & ~tick_prev_q;
    assign raw         = ACTIVE_LOW ? ~btn_s2_q : btn_s2_q;

    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            level_d[i]   = 1'b0;

            if (sample_en_q) begin
                unique case (state_q[i])
                    StIdle: begin
                        if (raw[i]) begin
                            state_d[i] = StPressWait;
                            cnt_d[i]   = 4'd1;
                        end
                    end
                    StPressWait: begin
                        if (!raw[i]) begin
                            state_d[i] = StIdle;
                            cnt_d[i]   = 4'd0;
                        end else if ((cnt_q[i] + 4'd1) == StableCnt) begin
                            state_d[i] = StPressed;
                            cnt_d[i]   = 4'd0;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end
                    StPressed: begin
                        if (!raw[i]) begin
                            state_d[i] = StReleaseWait;
                            cnt_d[i]   = 4'd1;
                        end
                    end
                    StReleaseWait: begin
                        if (raw[i]) begin
                            state_d[i] = StPressed;
                            cnt_d[i]   = 4'd0;
                        end else if ((cnt_q[i] + 4'd1) == StableCnt) begin
                            state_d[i]   = StIdle;
                            cnt_d[i]     = 4'd0;
                            release_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 4'd1;
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = 4'd0;
                    end
                endcase
            end

            level_d[i] = (state_d[i] == StPressed) || (state_d[i] == StReleaseWait);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q    <= BtnInactive;
            btn_s2_q    <= BtnInactive;
            tick_s1_q   <= 1'b0;
            tick_s2_q   <= 1'b0;
            tick_prev_q <= 1'b0;
            sample_en_q <= 1'b0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= 4'd0;
            end
        end else begin
            btn_s1_q    <= btn_in;
            btn_s2_q    <= btn_s1_q;
            tick_s1_q   <= tick_in;
            tick_s2_q   <= tick_s1_q;
            tick_prev_q <= tick_s2_q;
            sample_en_q <= sample_en_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed plus randomised bench for button_debouncer; expectations come from a per-button
// run-length model of accepted level changes.
module tb_button_debouncer;

    localparam int NB = 4;
    localparam int SS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_in = 1'b0;
    logic [NB-1:0] btn_in = '1;
    logic [NB-1:0] btn_level, btn_press, btn_release;

    button_debouncer #(
        .NUM_BUTTONS   (NB),
        .STABLE_SAMPLES(SS),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    int            passed = 0;
    int            total  = 0;
    int            run_m [NB];
    logic [NB-1:0] lvl_m, prs_m, rel_m, old_lvl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Count consecutive samples disagreeing with the accepted level; SS of them flip it.
    task automatic model_sample();
        logic [NB-1:0] pressed_now;
        pressed_now = ~btn_in;
        prs_m = '0;
        rel_m = '0;
        for (int i = 0; i < NB; i++) begin
            if (pressed_now[i] != lvl_m[i]) begin
                run_m[i]++;
                if (run_m[i] == SS) begin
                    lvl_m[i] = pressed_now[i];
                    run_m[i] = 0;
                    if (pressed_now[i]) prs_m[i] = 1'b1;
                    else rel_m[i] = 1'b1;
                end
            end else begin
                run_m[i] = 0;
            end
        end
    endtask

    task automatic model_reset();
        lvl_m = '0;
        prs_m = '0;
        rel_m = '0;
        for (int i = 0; i < NB; i++) run_m[i] = 0;
    endtask

    // Called at the negedge where a sample trigger appears; result is due on the 4th posedge.
    task automatic observe(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " pre level"}, 32'(btn_level), 32'(old_lvl));
        check({tag, " pre press"}, 32'(btn_press), 32'(0));
        check({tag, " pre release"}, 32'(btn_release), 32'(0));
        @(posedge clk);
        #1;
        check({tag, " level"}, 32'(btn_level), 32'(lvl_m));
        check({tag, " press"}, 32'(btn_press), 32'(prs_m));
        check({tag, " release"}, 32'(btn_release), 32'(rel_m));
        check({tag, " exclusive"}, 32'(btn_press & btn_release), 32'(0));
        @(posedge clk);
        #1;
        check({tag, " press width"}, 32'(btn_press), 32'(0));
        check({tag, " release width"}, 32'(btn_release), 32'(0));
    endtask

    task automatic tick(input logic [NB-1:0] btn, input int hold, input string tag);
        @(negedge clk);
        btn_in = btn;
        repeat (3) @(negedge clk);
        tick_in = 1'b1;
        old_lvl = lvl_m;
        model_sample();
        observe(tag);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        tick_in = 1'b0;
    endtask

    task automatic do_reset(input logic with_tick, input logic [NB-1:0] btn, input string tag);
        @(negedge clk);
        btn_in  = btn;
        rst     = 1'b1;
        tick_in = with_tick;
        repeat (3) @(posedge clk);
        #1;
        check({tag, " rst level"}, 32'(btn_level), 32'(0));
        check({tag, " rst press"}, 32'(btn_press), 32'(0));
        check({tag, " rst release"}, 32'(btn_release), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        if (with_tick) begin
            old_lvl = lvl_m;
            model_sample();
            observe({tag, " tick at release"});
            @(negedge clk);
            tick_in = 1'b0;
        end else begin
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] cur;
        model_reset();
        old_lvl = '0;

        // All pins low means all pressed: nothing until the 4th sample, then all pulse together.
        do_reset(1'b0, 4'b0000, "por");
        for (int k = 0; k < 4; k++) tick(4'b0000, 0, "all press");
        for (int k = 0; k < 4; k++) tick(4'b1111, 0, "all release");

        for (int k = 0; k < 4; k++) tick(4'b1110, 0, "clean press");
        for (int k = 0; k < 4; k++) tick(4'b1111, 0, "release0");

        tick(4'b1110, 0, "bounce p1");
        tick(4'b1110, 0, "bounce p2");
        tick(4'b1111, 0, "bounce r");
        for (int k = 0; k < 4; k++) tick(4'b1110, 0, "bounce run");

        tick(4'b1111, 50, "long tick");
        for (int k = 0; k < 3; k++) tick(4'b1111, 0, "release after long");

        for (int k = 0; k < 4; k++) tick(4'b0101, 0, "press 1+3");
        for (int k = 0; k < 4; k++) tick(4'b1111, 0, "release 1+3");

        for (int k = 0; k < 3; k++) tick(4'b1101, 0, "partial");
        do_reset(1'b0, 4'b1101, "mid reset");
        for (int k = 0; k < 4; k++) tick(4'b1101, 0, "fresh count");
        for (int k = 0; k < 4; k++) tick(4'b1111, 0, "fresh release");

        do_reset(1'b1, 4'b1110, "tick reset");
        for (int k = 0; k < 3; k++) tick(4'b1110, 0, "after tick reset");

        cur = 4'b1110;
        for (int k = 0; k < 80; k++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 3) == 0) cur[i] = ~cur[i];
            tick(cur, int'($urandom_range(0, 5)), "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 4: number of independent button channels.
REQ-002 SHALL have parameter STABLE_SAMPLES, default 4, legal range 2..15: number of consecutive agreeing samples needed to accept a change.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: when 1, a physical 0 on btn_in means pressed.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port tick_in, input, 1 bit: slow sampling clock from the time counter stage, treated as data (never used as a clock).
REQ-007 SHALL have port btn_in, input, NUM_BUTTONS bits: raw asynchronous push-button pins.
REQ-008 SHALL have port btn_level, output, NUM_BUTTONS bits: debounced level, 1 = pressed.
REQ-009 SHALL have port btn_press, output, NUM_BUTTONS bits: one-clk pulse on an accepted press.
REQ-010 SHALL have port btn_release, output, NUM_BUTTONS bits: one-clk pulse on an accepted release.

Function
REQ-011 SHALL pass btn_in through a 2-flop synchronizer per bit; raw = synchronized value, inverted when ACTIVE_LOW=1.
REQ-012 SHALL pass tick_in through a 2-flop synchronizer followed by a rising-edge detector, producing sample_en, a pulse exactly one clk wide.
REQ-013 SHALL treat tick_in held high for any number of clk cycles as exactly one sample.
REQ-014 SHALL run one FSM per button with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a 4-bit consecutive-sample counter cnt.
REQ-015 SHALL hold all state and counters unchanged in any cycle without sample_en.
REQ-016 IDLE: on sample_en with raw=1, go to PRESS_WAIT with cnt=1; with raw=0, stay.
REQ-017 PRESS_WAIT: on sample_en with raw=0, go to IDLE with cnt=0.
REQ-018 PRESS_WAIT: on sample_en with raw=1 and cnt+1<STABLE_SAMPLES, increment cnt.
REQ-019 PRESS_WAIT: on sample_en with raw=1 and cnt+1=STABLE_SAMPLES, go to PRESSED with cnt=0.
REQ-020 PRESSED and RELEASE_WAIT SHALL mirror IDLE and PRESS_WAIT with raw polarity inverted, ending in IDLE.
REQ-021 btn_level[i] SHALL be registered, 1 exactly while FSM i is in PRESSED or RELEASE_WAIT.
REQ-022 btn_press[i] SHALL be high for exactly the one clk cycle in which btn_level[i] first reads 1 after PRESS_WAIT->PRESSED.
REQ-023 btn_release[i] SHALL be high for exactly the one clk cycle in which btn_level[i] first reads 0 after RELEASE_WAIT->IDLE.
REQ-024 btn_press[i] and btn_release[i] SHALL never be high in the same cycle.
REQ-025 Channels SHALL be fully independent; simultaneous accepted changes on several buttons SHALL pulse in the same cycle.
REQ-026 Latency from the tick_in rising edge completing acceptance to the output pulse SHALL be 4 clk cycles (2 sync + 1 edge detect + 1 state register), given btn_in already stable ≥2 clk cycles before it.

Reset
REQ-027 On rst=1 at a clk edge, all FSMs SHALL go to IDLE, cnt=0, and btn_level, btn_press and btn_release SHALL all be 0.
REQ-028 On reset, btn synchronizer flops SHALL load the inactive pin level (1 if ACTIVE_LOW=1, else 0); tick synchronizer and edge-detect flops SHALL load 0.
REQ-029 tick_in already high at reset release SHALL produce one sample_en.
REQ-030 Reset asserted mid-PRESS_WAIT or mid-RELEASE_WAIT SHALL discard partial counts, with no press or release pulse generated.

Verification
REQ-031 Reset: rst=1 for 3 clk cycles with btn_in=4'b0000 -> all outputs 0; btn_level stays 0 until 4 sample_en pulses have occurred after release.
REQ-032 Clean press: btn_in[0] goes 1->0 and is held, tick_in toggles every 8 clk cycles -> btn_press[0]=1 for exactly one cycle, 4 clk cycles after the 4th tick rising edge; btn_level[0]=1 from then on; other bits stay 0.
REQ-033 Bounce: raw samples on button 0 are pressed, pressed, released, then pressed x4 -> no pulse until the 4th of the final run; exactly one btn_press[0] pulse.
REQ-034 Release and width: from PRESSED, hold btn_in[0]=1 for 4 ticks -> one btn_release[0] pulse and btn_level[0]=0; separately, tick_in held high for 50 clk cycles -> cnt advances by 1 only.
REQ-035 Simultaneous and reset-mid-count: press buttons 1 and 3 on the same tick -> both press pulses in the same cycle; separately, assert rst after 3 accepted samples -> 4 fresh samples are required, with no spurious pulse.
